// File: rtl/asrv32_lsu_wb_if.sv
// Pipelined Wishbone bundle between the asrv32 load/store unit (master) and the data bus (slave).
interface asrv32_lsu_wb_if #(
  parameter int ADDR_W = 32
);
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_adr;
  logic [3:0]        o_wb_sel;
  logic [31:0]       o_wb_dat;
  logic [31:0]       i_wb_dat;
  logic              i_wb_ack;
  logic              i_wb_err;
  logic              i_wb_stall;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
    input  i_wb_dat, i_wb_ack, i_wb_err, i_wb_stall
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
    output i_wb_dat, i_wb_ack, i_wb_err, i_wb_stall
  );
endinterface

// File: rtl/asrv32_lsu_wb.sv
// asrv32 MEM-stage load/store unit driving a pipelined Wishbone master, with response timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with an error and no bus cycle.
module asrv32_lsu_wb #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_rd,
  output logic [4:0]        o_rd_addr,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  asrv32_lsu_wb_if.master   wb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [3:0]        r_sel;
  logic [31:0]       r_dat;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_rd;
  logic              r_err;
  logic [4:0]        r_rd_addr;
  logic [31:0]       r_rdata;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_kill;
  logic              r_is_load;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [4:0]        r_rd_q;

  logic              w_accept;
  logic              w_trap;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdat;
  logic [31:0]       w_ld_data;
  logic              w_resp_evt;
  logic              w_to_hit;
  logic              w_fin;
  logic              w_fin_err;
  logic              w_kill_now;

  function automatic logic [3:0] f_sel(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   f_sel = 4'b0001 << off;
      2'b01:   f_sel = off[1] ? 4'b1100 : 4'b0011;
      default: f_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdat(input logic [1:0] sz, input logic [1:0] off,
                                         input logic [31:0] wdata);
    case (sz)
      2'b00:   f_wdat = wdata << {off, 3'b000};
      2'b01:   f_wdat = off[1] ? {wdata[15:0], 16'h0000} : wdata;
      default: f_wdat = wdata;
    endcase
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] dat, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = dat[7:0];
      2'b01:   b = dat[15:8];
      2'b10:   b = dat[23:16];
      default: b = dat[31:24];
    endcase
    h = off[1] ? dat[31:16] : dat[15:0];
    case (f3[1:0])
      2'b00:   f_extract = f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   f_extract = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
      default: f_extract = dat;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic f_misalign(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   f_misalign = 1'b0;
      2'b01:   f_misalign = off[0];
      default: f_misalign = (off != 2'b00);
    endcase
  endfunction
`endif

  // Request decode, lane steering and response/timeout qualification.
  always_comb begin
    w_accept   = i_valid && (i_load || i_store) && !i_flush && !r_busy;
`ifdef MISALIGN_TRAP_EN
    w_trap     = f_misalign(i_funct3[1:0], i_addr[1:0]);
`else
    w_trap     = 1'b0;
`endif
    w_sel      = f_sel(i_funct3[1:0], i_addr[1:0]);
    w_wdat     = f_wdat(i_funct3[1:0], i_addr[1:0], i_wdata);
    w_ld_data  = f_extract(wb.i_wb_dat, r_funct3, r_off);
    w_resp_evt = wb.i_wb_ack || wb.i_wb_err;
    w_to_hit   = (r_to_cnt == TO_LAST);
    w_fin      = w_resp_evt || w_to_hit;
    // A missing response at the timeout limit is reported as an error; err beats ack.
    w_fin_err  = wb.i_wb_err || !w_resp_evt;
    w_kill_now = r_kill || i_flush;
  end

  // Access sequencer: single FSM owning every registered output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= {ADDR_W{1'b0}};
      r_sel     <= 4'b0000;
      r_dat     <= 32'h0000_0000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_rd   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_addr <= 5'd0;
      r_rdata   <= 32'h0000_0000;
      r_to_cnt  <= {TO_W{1'b0}};
      r_kill    <= 1'b0;
      r_is_load <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= 2'b00;
      r_rd_q    <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_wr_rd <= 1'b0;
          r_err   <= 1'b0;
          if (w_accept) begin
            r_is_load <= i_load;
            r_funct3  <= i_funct3;
            r_off     <= i_addr[1:0];
            r_rd_q    <= i_rd_addr;
            r_kill    <= 1'b0;
            r_to_cnt  <= {TO_W{1'b0}};
            r_busy    <= 1'b1;
            if (w_trap) begin
              r_state   <= S_RESP;
              r_done    <= 1'b1;
              r_err     <= 1'b1;
              r_rd_addr <= i_rd_addr;
              r_rdata   <= 32'h0000_0000;
            end else begin
              r_state <= S_REQ;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= i_store;
              r_adr   <= {i_addr[ADDR_W-1:2], 2'b00};
              r_sel   <= w_sel;
              r_dat   <= w_wdat;
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_kill <= w_kill_now;
          if (w_fin) begin
            r_state   <= S_RESP;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= w_fin_err && !w_kill_now;
            r_wr_rd   <= r_is_load && !w_fin_err && !w_kill_now;
            r_rd_addr <= r_rd_q;
            r_rdata   <= w_resp_evt ? w_ld_data : 32'h0000_0000;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if ((r_state == S_REQ) && !wb.i_wb_stall) begin
              r_stb   <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_wr_rd <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_kill  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wr_rd     = r_wr_rd;
  assign o_rd_addr   = r_rd_addr;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign wb.o_wb_cyc = r_cyc;
  assign wb.o_wb_stb = r_stb;
  assign wb.o_wb_we  = r_we;
  assign wb.o_wb_adr = r_adr;
  assign wb.o_wb_sel = r_sel;
  assign wb.o_wb_dat = r_dat;

endmodule
